// File: rtl/frame_capture_sequencer_pkg.sv
// rtl/frame_capture_sequencer_pkg.sv - shared types and constants for the frame capture sequencer
//
// Contents:
//   fcs_state_e       3-bit sequencer state encoding
//   BURST_CMD_DEFAULT camera FIFO burst-read command byte
//   SPI_DUMMY_BYTE    byte clocked out while reading pixel bytes
//   sat_inc32()       saturating 32-bit increment for the tick counters

package frame_capture_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD_REQ   = 3'd1,
      ST_CMD_WAIT  = 3'd2,
      ST_BYTE_REQ  = 3'd3,
      ST_BYTE_WAIT = 3'd4,
      ST_PIX_OUT   = 3'd5,
      ST_DONE      = 3'd6
   } fcs_state_e;

   localparam logic [7:0] BURST_CMD_DEFAULT = 8'h3C;
   localparam logic [7:0] SPI_DUMMY_BYTE    = 8'h00;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/rgb565_byte_packer.sv
// rtl/rgb565_byte_packer.sv - assembles two SPI bytes into one RGB565 pixel
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clr         drops a half-assembled pixel (phase back to high byte)
//   byte_stb    one received byte is valid on byte_in this cycle
//   byte_in     received byte; first goes to pixel[15:8], second to pixel[7:0]
//   pixel       assembled pixel, held until the next strobe overwrites it
//   pixel_done  this strobe carries the second (low) byte of a pixel

module rgb565_byte_packer
   import frame_capture_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_stb,
   input  logic [7:0]  byte_in,
   output logic [15:0] pixel,
   output logic        pixel_done
);

   logic        phase_q, phase_d;
   logic [15:0] pixel_q, pixel_d;

   always_comb begin
      phase_d = phase_q;
      pixel_d = pixel_q;
      if (clr) begin
         phase_d = 1'b0;
      end else if (byte_stb) begin
         if (phase_q) begin
            pixel_d[7:0] = byte_in;
         end else begin
            pixel_d[15:8] = byte_in;
         end
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 1'b0;
         pixel_q <= 16'h0000;
      end else begin
         phase_q <= phase_d;
         pixel_q <= pixel_d;
      end
   end

   assign pixel      = pixel_q;
   // Combinational so the sequencer can pick PIX_OUT in the same cycle it latches the low byte.
   assign pixel_done = byte_stb && phase_q && !clr;

endmodule

// File: rtl/frame_capture_sequencer.sv
// rtl/frame_capture_sequencer.sv - reads one camera frame over SPI and streams it as RGB565 pixels
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   start, abort                capture request / cancel of the capture in progress
//   busy, done                  capture in progress / one-cycle completion pulse
//   spi_trigger, spi_tx_data    byte transfer request and the byte to send
//   spi_busy, spi_rx_byte       transfer in progress and the last byte received
//   pix_valid, pix_data         pixel offer, held until pix_ready
//   pix_ready                   downstream accepts the pixel
//   pix_col, pix_row            coordinates of the offered pixel
//   pix_eol, pix_eof            last pixel of row / of frame (qualified by pix_valid)
//   capture_ticks, stall_ticks  busy-cycle count and backpressure-cycle count (saturating)

module frame_capture_sequencer
   import frame_capture_sequencer_pkg::*;
#(
   parameter int unsigned IMAGE_WIDTH  = 320,
   parameter int unsigned IMAGE_HEIGHT = 240,
   parameter logic [7:0]  BURST_CMD    = BURST_CMD_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        spi_trigger,
   output logic [7:0]  spi_tx_data,
   input  logic        spi_busy,
   input  logic [7:0]  spi_rx_byte,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   input  logic        pix_ready,
   output logic [15:0] pix_col,
   output logic [15:0] pix_row,
   output logic        pix_eol,
   output logic        pix_eof,
   output logic [31:0] capture_ticks,
   output logic [31:0] stall_ticks
);

   localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

   fcs_state_e  state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        spi_trigger_q, spi_trigger_d;
   logic [7:0]  spi_tx_data_q, spi_tx_data_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [31:0] capture_ticks_q, capture_ticks_d;
   logic [31:0] stall_ticks_q, stall_ticks_d;

   logic        byte_stb;
   logic        pixel_done;

   // A byte is consumed when its transfer finishes while we wait on it; an abort
   // in the same cycle throws the byte away.
   assign byte_stb = (state_q == ST_BYTE_WAIT) && !spi_busy && !abort;

   rgb565_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (abort),
      .byte_stb   (byte_stb),
      .byte_in    (spi_rx_byte),
      .pixel      (pix_data),
      .pixel_done (pixel_done)
   );

   always_comb begin
      state_d         = state_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      spi_trigger_d   = spi_trigger_q;
      spi_tx_data_d   = spi_tx_data_q;
      pix_valid_d     = pix_valid_q;
      col_d           = col_q;
      row_d           = row_q;
      // Counters run independently of the state flow; start overrides below.
      capture_ticks_d = busy_q ? sat_inc32(capture_ticks_q) : capture_ticks_q;
      stall_ticks_d   = (pix_valid_q && !pix_ready) ? sat_inc32(stall_ticks_q) : stall_ticks_q;

      if ((state_q != ST_IDLE) && abort) begin
         // Abort leaves coordinates and counters where they stopped.
         state_d       = ST_IDLE;
         busy_d        = 1'b0;
         spi_trigger_d = 1'b0;
         pix_valid_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d         = ST_CMD_REQ;
                  busy_d          = 1'b1;
                  spi_trigger_d   = 1'b1;
                  spi_tx_data_d   = BURST_CMD;
                  col_d           = 16'd0;
                  row_d           = 16'd0;
                  capture_ticks_d = 32'd0;
                  stall_ticks_d   = 32'd0;
               end
            end
            ST_CMD_REQ: begin
               if (spi_busy) begin
                  state_d       = ST_CMD_WAIT;
                  spi_trigger_d = 1'b0;
               end
            end
            ST_CMD_WAIT: begin
               if (!spi_busy) begin
                  state_d       = ST_BYTE_REQ;
                  spi_trigger_d = 1'b1;
                  spi_tx_data_d = SPI_DUMMY_BYTE;
               end
            end
            ST_BYTE_REQ: begin
               if (spi_busy) begin
                  state_d       = ST_BYTE_WAIT;
                  spi_trigger_d = 1'b0;
               end
            end
            ST_BYTE_WAIT: begin
               if (!spi_busy) begin
                  if (pixel_done) begin
                     state_d     = ST_PIX_OUT;
                     pix_valid_d = 1'b1;
                  end else begin
                     state_d       = ST_BYTE_REQ;
                     spi_trigger_d = 1'b1;
                     spi_tx_data_d = SPI_DUMMY_BYTE;
                  end
               end
            end
            ST_PIX_OUT: begin
               if (pix_ready) begin
                  pix_valid_d = 1'b0;
                  if ((col_q == LAST_COL) && (row_q == LAST_ROW)) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     if (col_q == LAST_COL) begin
                        col_d = 16'd0;
                        row_d = row_q + 16'd1;
                     end else begin
                        col_d = col_q + 16'd1;
                     end
                     state_d       = ST_BYTE_REQ;
                     spi_trigger_d = 1'b1;
                     spi_tx_data_d = SPI_DUMMY_BYTE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d       = ST_IDLE;
               busy_d        = 1'b0;
               spi_trigger_d = 1'b0;
               pix_valid_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         spi_trigger_q   <= 1'b0;
         spi_tx_data_q   <= 8'h00;
         pix_valid_q     <= 1'b0;
         col_q           <= 16'd0;
         row_q           <= 16'd0;
         capture_ticks_q <= 32'd0;
         stall_ticks_q   <= 32'd0;
      end else begin
         state_q         <= state_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         spi_trigger_q   <= spi_trigger_d;
         spi_tx_data_q   <= spi_tx_data_d;
         pix_valid_q     <= pix_valid_d;
         col_q           <= col_d;
         row_q           <= row_d;
         capture_ticks_q <= capture_ticks_d;
         stall_ticks_q   <= stall_ticks_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign spi_trigger   = spi_trigger_q;
   assign spi_tx_data   = spi_tx_data_q;
   assign pix_valid     = pix_valid_q;
   assign pix_col       = col_q;
   assign pix_row       = row_q;
   assign pix_eol       = pix_valid_q && (col_q == LAST_COL);
   assign pix_eof       = pix_eol && (row_q == LAST_ROW);
   assign capture_ticks = capture_ticks_q;
   assign stall_ticks   = stall_ticks_q;

endmodule

// File: doc/frame_capture_sequencer.md
FRAME_CAPTURE_SEQUENCER -- requirements
Module: frame_capture_sequencer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 320, pixels per row.
REQ-002 Parameter IMAGE_HEIGHT, default 240, rows per frame.
REQ-003 Parameter BURST_CMD, default 8'h3C, camera FIFO burst-read command byte.
REQ-004 Port clk, in, 1, single clock; all logic on its rising edge.
REQ-005 Port rst, in, 1, reset, synchronous and active-high.
REQ-006 Port start, in, 1, one-cycle frame capture request.
REQ-007 Port abort, in, 1, cancel the capture in progress.
REQ-008 Port busy, out, 1, high from start acceptance until DONE or abort.
REQ-009 Port done, out, 1, one-cycle pulse at frame completion.
REQ-010 Port spi_trigger / spi_tx_data, out, 1 / 8, SPI byte request and byte to send.
REQ-011 Port spi_busy / spi_rx_byte, in, 1 / 8, SPI transfer in progress and last received byte.
REQ-012 Port pix_valid / pix_data, out, 1 / 16, RGB565 pixel offer.
REQ-013 Port pix_ready, in, 1, downstream accepts the pixel.
REQ-014 Port pix_col / pix_row, out, 16 / 16, coordinates of the pixel on pix_data.
REQ-015 Port pix_eol / pix_eof, out, 1 / 1, last pixel of row / last pixel of frame, qualified by pix_valid.
REQ-016 Port capture_ticks / stall_ticks, out, 32 / 32, busy-cycle count and backpressure-cycle count.

Function
REQ-017 States SHALL be IDLE, CMD_REQ, CMD_WAIT, BYTE_REQ, BYTE_WAIT, PIX_OUT and DONE.
REQ-018 IDLE: start with abort low -> CMD_REQ next cycle; busy=1; col, row and both tick counters cleared.
REQ-019 CMD_REQ: spi_trigger=1 and spi_tx_data=BURST_CMD; on spi_busy=1 -> CMD_WAIT with spi_trigger=0.
REQ-020 CMD_WAIT: on spi_busy=0 -> BYTE_REQ.
REQ-021 BYTE_REQ: spi_trigger=1 and spi_tx_data=8'h00; on spi_busy=1 -> BYTE_WAIT with spi_trigger=0.
REQ-022 BYTE_WAIT: on spi_busy=0, latch spi_rx_byte.
- The first byte of a pixel is pix_data[15:8] and the second is pix_data[7:0].
- After the first byte -> BYTE_REQ; after the second byte -> PIX_OUT.
REQ-023 PIX_OUT: pix_valid=1; pix_data, pix_col and pix_row SHALL stay stable until pix_valid&&pix_ready.
REQ-024 Handshake in PIX_OUT:
- Non-final pixel: col increments; at col==IMAGE_WIDTH-1, col->0 and row increments; state -> BYTE_REQ.
- Final pixel (col==IMAGE_WIDTH-1, row==IMAGE_HEIGHT-1): -> DONE.
REQ-025 pix_eol=1 when col==IMAGE_WIDTH-1; pix_eof=1 when additionally row==IMAGE_HEIGHT-1.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 in that cycle, -> IDLE.
REQ-027 Latency: start accepted in cycle N gives spi_trigger=1 in cycle N+1.
REQ-028 Latency: the second-byte latch in cycle N gives pix_valid=1 in cycle N+1.
REQ-029 abort in any non-IDLE state -> IDLE next cycle.
- busy, spi_trigger and pix_valid go 0; done is not pulsed.
- Counters hold their values.
REQ-030 start while busy SHALL be ignored; start and abort together in IDLE: abort wins and no capture begins.
REQ-031 capture_ticks increments every cycle busy=1; stall_ticks increments every cycle pix_valid&&!pix_ready.
REQ-032 Both tick counters saturate at 32'hFFFFFFFF and do not wrap.
REQ-033 spi_trigger SHALL be 0 in IDLE, DONE and PIX_OUT.
REQ-034 pix_valid SHALL be 0 outside PIX_OUT.

Reset
REQ-035 rst SHALL dominate all inputs, including start and abort in the same cycle.
REQ-036 On rst: state IDLE; busy, done, spi_trigger, pix_valid, pix_eol and pix_eof = 0.
REQ-037 On rst: spi_tx_data, pix_data, pix_col, pix_row, capture_ticks and stall_ticks = 0.
REQ-038 rst mid-frame SHALL behave as abort and additionally clear all counters.

Structure
REQ-039 A shared package SHALL hold the state encoding (3-bit enum) and the BURST_CMD default constant.
REQ-040 Byte-to-pixel assembly SHALL be one sub-module, rgb565_byte_packer.
- Inputs: byte strobe and byte; output: 16-bit pixel plus pixel-complete flag.
- Phase toggle cleared on rst or abort.

Verification
REQ-041 WIDTH=4, HEIGHT=2, pix_ready=1, SPI model returns 8'hA0+n -> first beat pix_data=16'hA0A1 at col0/row0; 8 pixels; eol at col3; eof only on 8th; done pulses once.
REQ-042 Same setup, pix_ready low for 5 cycles on pixel 2 -> pix_data held stable; stall_ticks=5; sequence unchanged.
REQ-043 First SPI request after start -> spi_tx_data=8'h3C with spi_trigger=1; all later requests carry 8'h00.
REQ-044 abort asserted in BYTE_WAIT of pixel 3 -> IDLE next cycle, busy=0, no done; a new start restarts at col0/row0 with counters cleared.
REQ-045 start and abort together in IDLE -> busy stays 0; start pulses while busy -> capture_ticks unaffected and frame completes normally.
REQ-046 rst asserted mid-frame together with start -> all outputs and counters 0 next cycle; state IDLE.
